// File: rtl/time_counter.sv
// Current-time keeper for the alarm clock: BCD HH:MM counter advanced by the
// one_minute tick, with validated time load and a realignment pulse back to the timing generator.
module time_counter #(
   parameter bit HOUR_MODE_24 = 1'b1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       one_minute,
   input  logic       load_new_c,
   input  logic [3:0] new_ms_hr,
   input  logic [3:0] new_ls_hr,
   input  logic [3:0] new_ms_min,
   input  logic [3:0] new_ls_min,
   input  logic       new_pm,
   output logic [3:0] ms_hr,
   output logic [3:0] ls_hr,
   output logic [3:0] ms_min,
   output logic [3:0] ls_min,
   output logic       pm,
   output logic       reset_count,
   output logic       load_error,
   output logic       day_tick
);

   // Reset time: 00:00 in 24h counting, 12:00 AM in 12h counting.
   localparam logic [3:0] RST_MS_HR = HOUR_MODE_24 ? 4'd0 : 4'd1;
   localparam logic [3:0] RST_LS_HR = HOUR_MODE_24 ? 4'd0 : 4'd2;

   function automatic logic time_ok(input logic [3:0] mh, input logic [3:0] lh,
                                    input logic [3:0] mm, input logic [3:0] lm);
      logic ok;
      ok = (mh <= 4'd9) && (lh <= 4'd9) && (mm <= 4'd5) && (lm <= 4'd9);
      if (HOUR_MODE_24)
         ok = ok && (mh <= 4'd2) && !((mh == 4'd2) && (lh > 4'd3));
      else
         ok = ok && (mh <= 4'd1) && !((mh == 4'd1) && (lh > 4'd2))
                 && !((mh == 4'd0) && (lh == 4'd0));
      return ok;
   endfunction

   logic       load_ok;
   logic       state_ok;
   logic [3:0] ms_hr_n, ls_hr_n, ms_min_n, ls_min_n;
   logic       pm_n, reset_count_n, load_error_n, day_tick_n;

   // load_new_c is a one-cycle request with no ready side: it is resolved in the
   // cycle it is seen, and the outcome appears next cycle as reset_count (accepted)
   // or load_error (rejected). Either way a coincident one_minute is discarded.
   assign load_ok  = time_ok(new_ms_hr, new_ls_hr, new_ms_min, new_ls_min);
   assign state_ok = time_ok(ms_hr, ls_hr, ms_min, ls_min) && !(HOUR_MODE_24 && pm);

   always_comb begin
      ms_hr_n       = ms_hr;
      ls_hr_n       = ls_hr;
      ms_min_n      = ms_min;
      ls_min_n      = ls_min;
      pm_n          = pm;
      reset_count_n = 1'b0;
      load_error_n  = 1'b0;
      day_tick_n    = 1'b0;

      if (load_new_c) begin
         if (load_ok) begin
            ms_hr_n       = new_ms_hr;
            ls_hr_n       = new_ls_hr;
            ms_min_n      = new_ms_min;
            ls_min_n      = new_ls_min;
            pm_n          = HOUR_MODE_24 ? 1'b0 : new_pm;
            reset_count_n = 1'b1;
         end else begin
            load_error_n  = 1'b1;
         end
      end else if (!state_ok) begin
         ms_hr_n  = RST_MS_HR;
         ls_hr_n  = RST_LS_HR;
         ms_min_n = 4'd0;
         ls_min_n = 4'd0;
         pm_n     = 1'b0;
      end else if (one_minute) begin
         if (ls_min != 4'd9) begin
            ls_min_n = ls_min + 4'd1;
         end else begin
            ls_min_n = 4'd0;
            if (ms_min != 4'd5) begin
               ms_min_n = ms_min + 4'd1;
            end else begin
               ms_min_n = 4'd0;
               // Hour carry; the wrap points differ between the two counting modes.
               if (HOUR_MODE_24 && (ms_hr == 4'd2) && (ls_hr == 4'd3)) begin
                  ms_hr_n    = 4'd0;
                  ls_hr_n    = 4'd0;
                  day_tick_n = 1'b1;
               end else if (!HOUR_MODE_24 && (ms_hr == 4'd1) && (ls_hr == 4'd2)) begin
                  ms_hr_n = 4'd0;
                  ls_hr_n = 4'd1;
               end else if (!HOUR_MODE_24 && (ms_hr == 4'd1) && (ls_hr == 4'd1)) begin
                  ls_hr_n    = 4'd2;
                  pm_n       = !pm;
                  day_tick_n = pm;
               end else if (ls_hr == 4'd9) begin
                  ls_hr_n = 4'd0;
                  ms_hr_n = ms_hr + 4'd1;
               end else begin
                  ls_hr_n = ls_hr + 4'd1;
               end
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ms_hr       <= RST_MS_HR;
         ls_hr       <= RST_LS_HR;
         ms_min      <= 4'd0;
         ls_min      <= 4'd0;
         pm          <= 1'b0;
         reset_count <= 1'b0;
         load_error  <= 1'b0;
         day_tick    <= 1'b0;
      end else begin
         ms_hr       <= ms_hr_n;
         ls_hr       <= ls_hr_n;
         ms_min      <= ms_min_n;
         ls_min      <= ls_min_n;
         pm          <= pm_n;
         reset_count <= reset_count_n;
         load_error  <= load_error_n;
         day_tick    <= day_tick_n;
      end
   end

endmodule
